// File: rtl/reciprocal_sched.sv
// Round-robin scheduler sharing one Q6.10 reciprocal datapath among NUM_REQ requesters, one op outstanding.
// Response appears SETTLE+1 cycles after accept (1 for zero/negative operands) and is held until i_rsp_ready[id].
module reciprocal_sched #(
  parameter int NUM_REQ = 4,
  parameter int SETTLE  = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic [16*NUM_REQ-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  input  logic [NUM_REQ-1:0]     i_rsp_ready,
  output logic [15:0]            o_rsp_data,
  output logic                   o_rsp_err,
  output logic                   o_busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [14:0]     op_q, op_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW:0]    cand;
  logic [15:0]     operand;

  // Search upward from ptr+1, wrapping at NUM_REQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i + 1);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_vld && i_req_valid[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  assign operand = i_req_data[{gnt_idx, 4'b0000} +: 16];

  // Reciprocal datapath: normalise to m in [1,2), quadratic 1/m ~ 1 - 5t/6 + t^2/3 (t = m-1), rescale.
  logic [3:0]  lz_pos;
  logic [14:0] norm;
  logic [13:0] tf, t2;
  logic [27:0] sq;
  logic [29:0] prod_a;
  logic [28:0] prod_b;
  logic [15:0] a_term;
  logic [14:0] b_term;
  logic [16:0] poly;
  logic [20:0] scaled;
  logic [15:0] recip;

  always_comb begin
    lz_pos = '0;
    for (int i = 0; i < 15; i++)
      if (op_q[i]) lz_pos = 4'(i);
    norm   = op_q << (4'd14 - lz_pos);
    tf     = 14'(norm);
    sq     = 28'(tf) * 28'(tf);
    t2     = 14'(sq >> 14);
    prod_a = 30'(tf) * 30'(16'd54613);
    prod_b = 29'(t2) * 29'(15'd21845);
    a_term = 16'(prod_a >> 14);
    b_term = 15'(prod_b >> 14);
    poly   = 17'h10000 - 17'(a_term) + 17'(b_term);
    scaled = {poly, 4'b0000} >> lz_pos;
    recip  = (|scaled[20:15]) ? 16'h7FFF : scaled[15:0];
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          id_d  = gnt_idx;
          ptr_d = gnt_idx;
          op_d  = operand[14:0];
          if (operand == 16'h0000 || operand[15]) begin
            state_d    = RESP;
            rsp_data_d = 16'h7FFF;
            rsp_err_d  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(SETTLE - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          rsp_data_d = recip;
          rsp_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (i_rsp_ready[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ptr_q      <= IDW'(NUM_REQ - 1);
      id_q       <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      rsp_data_q <= 16'h0000;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    if (state_q == IDLE && gnt_vld) o_req_ready[gnt_idx] = 1'b1;
    if (state_q == RESP) o_rsp_valid[id_q] = 1'b1;
  end

  assign o_rsp_data = rsp_data_q;
  assign o_rsp_err  = rsp_err_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reciprocal_sched.sv
// Bench for reciprocal_sched: transaction-level model checked every cycle, directed scenarios, then random traffic.
module tb_reciprocal_sched;
  localparam int N      = 4;
  localparam int SETTLE = 2;

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    rsp_ready = '0;
  logic [16*N-1:0] req_data  = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [15:0]     rsp_data;
  logic            rsp_err, busy;

  always #5 clk = ~clk;

  reciprocal_sched #(.NUM_REQ(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rstn(rstn),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_data(req_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Datapath arithmetic: x/1024 = m*2^(p-10), m in [1,2); 1/m approximated by 1 - 5t/6 + t^2/3.
  function automatic logic [15:0] golden(input logic [15:0] x);
    int p;
    longint tf, t2, poly, r;
    if (x == 16'h0000 || x[15]) return 16'h7FFF;
    p = 0;
    for (int i = 0; i < 15; i++) if (x[i]) p = i;
    tf   = (longint'(x) << (14 - p)) - 16384;
    t2   = (tf * tf) >>> 14;
    poly = 65536 - ((54613 * tf) >>> 14) + ((21845 * t2) >>> 14);
    r    = (poly << 4) >>> p;
    return (r > 32767) ? 16'h7FFF : 16'(r);
  endfunction

  // Transaction model: one outstanding op, its age in edges, and the round-robin pointer.
  bit           m_busy = 0;
  int           m_id   = 0;
  int           m_age  = 0;
  int           m_ptr  = N - 1;
  logic [15:0]  m_data = '0;
  logic [15:0]  m_op   = '0;
  bit           m_err  = 0;
  logic [N-1:0] acc_vec = '0;
  int           acc_ids[$];
  int           acc_cyc[$];
  int           hs_cyc[$];
  logic [15:0]  hs_data[$];
  bit           hs_err[$];
  logic [N-1:0] hs_vld[$];
  int           cyc = 0;
  int           g;
  logic [N-1:0] exp_rdy, exp_vld;
  bit           shown;
  real          exact, diff;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      m_busy  = 0;
      m_ptr   = N - 1;
      acc_vec = '0;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(rsp_data),  32'd0);
      chk("rst_rsp_err",   32'(rsp_err),   32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
    end else begin
      g = -1;
      if (!m_busy)
        for (int i = 1; i <= N; i++)
          if (g < 0 && req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      shown   = m_busy && (m_age >= (m_err ? 0 : SETTLE));
      exp_vld = '0;
      if (shown) exp_vld[m_id] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
      chk("busy",      32'(busy),      32'(m_busy));
      if (shown) begin
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        chk("rsp_err",  32'(rsp_err),  32'(m_err));
        if (!m_err) begin
          exact = 1048576.0 / real'(int'(m_op));
          if (exact < 32000.0) begin
            diff = real'(int'(rsp_data)) - exact;
            if (diff < 0.0) diff = -diff;
            chk("recip_tolerance", 32'(diff <= exact * 0.02 + 2.0), 32'd1);
          end
        end
      end
      if (|(rsp_valid & rsp_ready)) begin
        hs_cyc.push_back(cyc);
        hs_data.push_back(rsp_data);
        hs_err.push_back(rsp_err);
        hs_vld.push_back(rsp_valid);
      end
      acc_vec = '0;
      if (m_busy) begin
        if (shown && rsp_ready[m_id]) m_busy = 0;
        else m_age++;
      end else if (g >= 0) begin
        m_op    = req_data[16*g +: 16];
        m_busy  = 1;
        m_id    = g;
        m_ptr   = g;
        m_age   = 0;
        m_err   = (m_op == 16'h0000) || m_op[15];
        m_data  = golden(m_op);
        acc_vec[g] = 1'b1;
        acc_ids.push_back(g);
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      tick();
      req_valid = req_valid & ~acc_vec;
    end
  endtask

  task automatic wait_acc(input int k);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_vec[k] && n < 40);
    chk("accept_seen", 32'(acc_vec[k]), 32'd1);
  endtask

  int base, hb;
  logic [15:0] rr_exp [4];
  logic [15:0] err_ops [2];

  initial begin
    rr_exp  = '{16'h0200, 16'h0800, 16'h0100, 16'h1000};
    err_ops = '{16'h0000, 16'h8400};

    chk("golden_1p0", 32'(golden(16'h0400)), 32'h0400);
    chk("golden_2p0", 32'(golden(16'h0800)), 32'h0200);
    chk("golden_1p5", 32'(golden(16'h0600)), 32'h02AA);
    chk("golden_neg", 32'(golden(16'h8400)), 32'h7FFF);

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    rsp_ready = '1;

    // Round robin from reset, all requesters held valid.
    base = acc_ids.size();
    hb   = hs_data.size();
    req_data  = {16'h0100, 16'h1000, 16'h0200, 16'h0800};
    req_valid = '1;
    repeat (18) tick();
    req_valid = '0;
    drain(8);
    chk("rr_count", 32'(acc_ids.size() - base >= 5), 32'd1);
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(acc_ids[base+i]), 32'(i % 4));
    for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(acc_cyc[base+i] - acc_cyc[base+i-1]), 32'(SETTLE + 2));
    for (int i = 0; i < 4; i++) begin
      chk("rr_data", 32'(hs_data[hb+i]), 32'(rr_exp[i]));
      chk("rr_onehot", 32'(hs_vld[hb+i]), 32'(1 << i));
    end

    // Single request, always-ready sink.
    base = acc_ids.size();
    hb   = hs_data.size();
    req_data[15:0] = 16'h0400;
    req_valid[0] = 1'b1;
    wait_acc(0);
    req_valid[0] = 1'b0;
    drain(6);
    chk("single_data",    32'(hs_data[hb]), 32'h0400);
    chk("single_err",     32'(hs_err[hb]),  32'd0);
    chk("single_onehot",  32'(hs_vld[hb]),  32'b0001);
    chk("single_latency", 32'(hs_cyc[hb] - acc_cyc[base]), 32'(SETTLE + 1));

    // Zero and negative operands bypass the datapath.
    for (int e = 0; e < 2; e++) begin
      base = acc_ids.size();
      hb   = hs_data.size();
      req_data[47:32] = err_ops[e];
      req_valid[2] = 1'b1;
      wait_acc(2);
      req_valid[2] = 1'b0;
      drain(4);
      chk("err_data",    32'(hs_data[hb]), 32'h7FFF);
      chk("err_flag",    32'(hs_err[hb]),  32'd1);
      chk("err_latency", 32'(hs_cyc[hb] - acc_cyc[base]), 32'd1);
    end

    // Backpressure on requester 1 while requester 0 waits; rsp_ready[0] toggles meanwhile.
    base = acc_ids.size();
    hb   = hs_data.size();
    rsp_ready = '0;
    req_data[31:16] = 16'h0600;
    req_valid[1] = 1'b1;
    wait_acc(1);
    req_valid[1] = 1'b0;
    req_data[15:0] = 16'h0400;
    req_valid[0] = 1'b1;
    repeat (SETTLE + 6) begin
      tick();
      rsp_ready[0] = ~rsp_ready[0];
    end
    rsp_ready = '1;
    wait_acc(0);
    req_valid[0] = 1'b0;
    drain(6);
    chk("bp_data",   32'(hs_data[hb]), 32'h02AA);
    chk("bp_onehot", 32'(hs_vld[hb]),  32'b0010);
    chk("bp_next",   32'(acc_ids[base+1]), 32'd0);
    chk("bp_hold",   32'(acc_cyc[base+1] - acc_cyc[base] >= 9), 32'd1);

    // Asynchronous reset while the operation is in WAIT.
    req_data[63:48] = 16'h0300;
    req_valid[3] = 1'b1;
    wait_acc(3);
    req_valid[3] = 1'b0;
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_busy",      32'(busy),      32'd0);
    chk("arst_rsp_data",  32'(rsp_data),  32'd0);
    hb = hs_data.size();
    @(posedge clk);
    #1 rstn = 1'b1;
    drain(5);
    chk("arst_no_rsp", 32'(hs_data.size() - hb), 32'd0);
    base = acc_ids.size();
    req_valid = '1;
    tick();
    req_valid = '0;
    chk("arst_first_grant", 32'(acc_ids[base]), 32'd0);
    drain(6);

    // Withdrawn request while busy must not move the pointer.
    base = acc_ids.size();
    req_data[31:16] = 16'h0400;
    req_valid[1] = 1'b1;
    wait_acc(1);
    req_valid[1] = 1'b0;
    req_data[47:32] = 16'h0A00;
    req_valid[2] = 1'b1;
    tick();
    req_valid[2] = 1'b0;
    drain(6);
    chk("wd_accepts", 32'(acc_ids.size() - base), 32'd1);
    chk("wd_idle",    32'(busy), 32'd0);
    req_valid = '1;
    tick();
    req_valid = '0;
    chk("wd_next_grant", 32'(acc_ids[base+1]), 32'd2);
    drain(6);

    // Random traffic: valid held until accepted (occasional legal withdrawal), random sink.
    repeat (3000) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (acc_vec[k]) req_valid[k] = 1'b0;
        else if (req_valid[k] && $urandom_range(15) == 0) req_valid[k] = 1'b0;
        if (!req_valid[k] && $urandom_range(2) == 0) begin
          case ($urandom_range(7))
            0:       req_data[16*k +: 16] = 16'h0000;
            1:       req_data[16*k +: 16] = {1'b1, 15'($urandom)};
            default: req_data[16*k +: 16] = 16'($urandom_range(32767, 1));
          endcase
          req_valid[k] = 1'b1;
        end
      end
      rsp_ready = N'($urandom) | N'($urandom);
    end
    req_valid = '0;
    rsp_ready = '1;
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
